// File: rtl/nf_ram_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : nf_ram_dma_if
//  Description : Command, status and RAM-port bundle for nf_ram_dma.
//                Command : start, op, src_addr, dst_addr, len, fill_data
//                Status  : busy, done, err, sum
//                RAM     : mem_addr, mem_we, mem_wd (to RAM), mem_rd (from RAM,
//                          combinational from mem_addr)
//                modport master : the DMA engine (drives status and RAM port)
//                modport slave  : its environment (drives command, returns mem_rd)
//  Revision    : 1.0  initial release
// ============================================================================
interface nf_ram_dma_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [1:0]       op;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill_data;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      sum;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;

    modport master (
        input  start, op, src_addr, dst_addr, len, fill_data, mem_rd,
        output busy, done, err, sum, mem_addr, mem_we, mem_wd
    );

    modport slave (
        output start, op, src_addr, dst_addr, len, fill_data, mem_rd,
        input  busy, done, err, sum, mem_addr, mem_we, mem_wd
    );
endinterface
`default_nettype wire

// File: rtl/nf_ram_dma.sv
`default_nettype none
// ============================================================================
//  Module      : nf_ram_dma
//  Description : Block-operation initiator for the single-port nf RAM.
//                One command per start: FILL a range with a constant, COPY a
//                range word by word (read then write), or SUM a range into a
//                32-bit wrap-around checksum.
//  Ports       : clk  - clock, all state updates on posedge
//                rst  - synchronous reset, active-high
//                bus  - nf_ram_dma_if.master (command, status, RAM port)
//  Revision    : 1.0  initial release
// ============================================================================
module nf_ram_dma #(
    parameter int LEN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    nf_ram_dma_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        COPY_RD = 3'd2,
        COPY_WR = 3'd3,
        SUM     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_fill;
    logic [31:0]      r_buf;
    logic [31:0]      r_sum;
    logic             r_err;

    logic [31:0]      w_mem_addr;
    logic             w_mem_we;
    logic [31:0]      w_mem_wd;
    logic             w_last;

    // The word counter is loaded with len and the final word is the one
    // processed while it reads 1.
    assign w_last = (r_cnt == LEN_W'(1));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and RAM-port outputs. The RAM port is decoded from registered
    // state only, so start never reaches mem_* in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mem_addr  = 32'd0;
        w_mem_we    = 1'b0;
        w_mem_wd    = 32'd0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.op == 2'b11) || (bus.len == '0)) begin
                        w_state_nxt = DONE;
                    end else if (bus.op == 2'b00) begin
                        w_state_nxt = FILL;
                    end else if (bus.op == 2'b01) begin
                        w_state_nxt = COPY_RD;
                    end else begin
                        w_state_nxt = SUM;
                    end
                end
            end
            FILL: begin
                w_mem_addr = r_dst;
                w_mem_we   = 1'b1;
                w_mem_wd   = r_fill;
                if (w_last) w_state_nxt = DONE;
            end
            COPY_RD: begin
                w_mem_addr  = r_src;
                w_state_nxt = COPY_WR;
            end
            COPY_WR: begin
                w_mem_addr  = r_dst;
                w_mem_we    = 1'b1;
                w_mem_wd    = r_buf;
                w_state_nxt = w_last ? DONE : COPY_RD;
            end
            SUM: begin
                w_mem_addr = r_src;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: command latch, pointers, counter, copy buffer, checksum, error.
    // The opcode itself is not kept: after acceptance the state encodes it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src  <= 32'd0;
            r_dst  <= 32'd0;
            r_cnt  <= '0;
            r_fill <= 32'd0;
            r_buf  <= 32'd0;
            r_sum  <= 32'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_src  <= bus.src_addr;
                        r_dst  <= bus.dst_addr;
                        r_cnt  <= bus.len;
                        r_fill <= bus.fill_data;
                        r_sum  <= 32'd0;
                        // Raised here so it is already visible in the DONE cycle.
                        r_err  <= (bus.op == 2'b11);
                    end
                end
                FILL: begin
                    r_dst <= r_dst + 32'd1;
                    r_cnt <= r_cnt - LEN_W'(1);
                end
                COPY_RD: begin
                    r_buf <= bus.mem_rd;
                    r_src <= r_src + 32'd1;
                end
                COPY_WR: begin
                    r_dst <= r_dst + 32'd1;
                    r_cnt <= r_cnt - LEN_W'(1);
                end
                SUM: begin
                    r_sum <= r_sum + bus.mem_rd;
                    r_src <= r_src + 32'd1;
                    r_cnt <= r_cnt - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.err      = r_err;
    assign bus.sum      = r_sum;
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_we   = w_mem_we;
    assign bus.mem_wd   = w_mem_wd;

endmodule
`default_nettype wire
